uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency used for divider constants.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_en  input  1  receiver enable; low forces IDLE.
REQ-005 SHALL have port baud_sel  input  3  baud code: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
REQ-006 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  last received byte.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse, frame accepted without error.
REQ-009 SHALL have port rx_perror  output  1  one-cycle pulse, parity mismatch.
REQ-010 SHALL have port rx_ferror  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port rx_busy  output  1  high while state is not IDLE.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer before any use; stage reset value 1.
REQ-013 SHALL generate a 16x sample tick: divider = CLK_HZ/(16*baud), rounded to nearest; at 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
REQ-014 SHALL latch baud_sel on start-edge detection; baud_sel changes mid-frame SHALL NOT affect the current frame.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START on synchronized high-to-low transition with rx_en=1; tick counter and divider restart at this cycle.
REQ-017 START: at tick 8, line low -> DATA; line high -> IDLE with no output (glitch rejection).
REQ-018 DATA: sample at tick 8 of each of 8 bit periods, LSB first, into a shift register; after bit 7 -> PARITY.
REQ-019 PARITY: sample at tick 8; expected value SHALL be even parity (XOR of 8 data bits); then -> STOP.
REQ-020 STOP: sample at tick 8, then -> IDLE in the next cycle, so a start edge arriving half a bit later is accepted (back-to-back frames).
REQ-021 On stop sample: rx_data SHALL load the shifted byte regardless of errors, one cycle after the stop sample.
REQ-022 In the same cycle: stop low -> rx_ferror=1; parity mismatch -> rx_perror=1; both may assert together; rx_valid=1 only when neither.
REQ-023 rx_valid, rx_perror, rx_ferror SHALL be high for exactly one clk cycle per frame; at most one frame outcome per frame.
REQ-024 rx_data SHALL hold its value until the next completed frame.
REQ-025 rx_en deasserted in any state SHALL return to IDLE in the next cycle, discarding the partial frame with no pulse.
REQ-026 A line held low continuously after a framing error SHALL NOT start a new frame until a high-to-low transition is seen.

Reset
REQ-027 reset=0 SHALL asynchronously force: state IDLE, rx_data=8'h00, rx_valid=0, rx_perror=0, rx_ferror=0, rx_busy=0, counters 0, synchronizer stages 1.
REQ-028 Reset asserted mid-frame SHALL discard the frame; after release, reception resumes only on a fresh start edge.

Configuration
REQ-029 Macro UART_RX_MAJORITY_EN defined: each bit value (start, data, parity, stop) SHALL be the 2-of-3 majority of samples at ticks 7, 8, 9, decision made at tick 9.
REQ-030 Macro UART_RX_MAJORITY_EN undefined: single sample at tick 8; no majority logic synthesized.

Verification
REQ-031 baud_sel=7, send 0xA5 parity 0 stop 1 -> one rx_valid pulse, rx_data=0xA5, no error pulses, frame ~4752 clocks.
REQ-032 baud_sel=7, send 0x01 with parity 0 -> rx_perror pulse, rx_valid low, rx_data=0x01.
REQ-033 baud_sel=3, send 0x3C with stop bit 0 -> rx_ferror pulse, rx_valid low; then idle high and send 0x55 -> rx_valid, rx_data=0x55.
REQ-034 baud_sel=7, low glitch of 100 clocks -> no output pulse, rx_busy returns low within 220 clocks.
REQ-035 Two back-to-back 115200 frames 0x12, 0x34 (no idle gap) -> two rx_valid pulses, data 0x12 then 0x34.
REQ-036 rx_en=0 or reset=0 during DATA of 0xFF -> no pulse, rx_busy low next cycle, rx_data unchanged (0x00 after reset).

Source files
------------

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling UART receiver, 8 data + even parity + 1 stop; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx_core #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic [2:0] baud_sel,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_perror,
    output logic       rx_ferror,
    output logic       rx_busy
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Clocks per 16x tick for each baud code, rounded to nearest.
    function automatic logic [15:0] f_div(input logic [2:0] code);
        int baud;
        case (code)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        return 16'((CLK_HZ + 8 * baud) / (16 * baud));
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rxd_s1;
    logic        r_rxd_s2;
    logic        r_rxd_prev;
    logic [2:0]  r_baud_sel;
    logic [15:0] r_div_cnt;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par_bit;
    logic [7:0]  r_rx_data;
    logic        r_valid;
    logic        r_perror;
    logic        r_ferror;
    logic [15:0] w_div;
    logic        w_fall;
    logic        w_start;
    logic        w_active;
    logic        w_tick;
    logic        w_samp;
    logic        w_bit;
    logic        w_par_err;

    // Two-flop synchronizer plus one history stage for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_s1   <= rxd;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_prev <= r_rxd_s2;
        end
    end

    assign w_fall    = r_rxd_prev & ~r_rxd_s2;
    assign w_start   = (r_state == S_IDLE) && rx_en && w_fall;
    assign w_active  = (r_state != S_IDLE);
    assign w_div     = f_div(r_baud_sel);
    assign w_tick    = w_active && (r_div_cnt == w_div - 16'd1);
    assign w_par_err = r_par_bit ^ (^r_shift);
    assign rx_busy   = w_active;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_valid;
    assign rx_perror = r_perror;
    assign rx_ferror = r_ferror;

    // Baud latch and tick generation; both counters restart on the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud_sel <= 3'd0;
            r_div_cnt  <= 16'd0;
            r_tick_cnt <= 4'd0;
        end else if (w_start) begin
            r_baud_sel <= baud_sel;
            r_div_cnt  <= 16'd0;
            r_tick_cnt <= 4'd0;
        end else if (!w_active) begin
            r_div_cnt  <= 16'd0;
            r_tick_cnt <= 4'd0;
        end else if (w_tick) begin
            r_div_cnt  <= 16'd0;
            r_tick_cnt <= r_tick_cnt + 4'd1;
        end else begin
            r_div_cnt  <= r_div_cnt + 16'd1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_samp7;
    logic r_samp8;

    // Hold the first two votes; the third is the live line at the decision tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp7 <= 1'b1;
            r_samp8 <= 1'b1;
        end else if (w_tick) begin
            if (r_tick_cnt == 4'd6) r_samp7 <= r_rxd_s2;
            if (r_tick_cnt == 4'd7) r_samp8 <= r_rxd_s2;
        end
    end

    assign w_samp = w_tick && (r_tick_cnt == 4'd8);
    assign w_bit  = (r_samp7 & r_samp8) | (r_samp7 & r_rxd_s2) | (r_samp8 & r_rxd_s2);
`else
    assign w_samp = w_tick && (r_tick_cnt == 4'd7);
    assign w_bit  = r_rxd_s2;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: advance one frame field per mid-bit sample; rx_en low aborts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_START;
            S_START:  if (w_samp)  w_state_nxt = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_samp && (r_bit_cnt == 3'd7)) w_state_nxt = S_PARITY;
            S_PARITY: if (w_samp)  w_state_nxt = S_STOP;
            S_STOP:   if (w_samp)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (!rx_en) w_state_nxt = S_IDLE;
    end

    // Shift in data bits, capture parity, and publish the byte and outcome at the stop sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par_bit <= 1'b0;
            r_rx_data <= 8'h00;
            r_valid   <= 1'b0;
            r_perror  <= 1'b0;
            r_ferror  <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_perror <= 1'b0;
            r_ferror <= 1'b0;
            if (rx_en && w_samp) begin
                case (r_state)
                    S_START:  r_bit_cnt <= 3'd0;
                    S_DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_par_bit <= w_bit;
                    S_STOP: begin
                        r_rx_data <= r_shift;
                        r_ferror  <= ~w_bit;
                        r_perror  <= w_par_err;
                        r_valid   <= w_bit & ~w_par_err;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core with a frame-level outcome model
module tb_uart_rx_core;

    localparam int CLK_HZ = 12_500_000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en = 1'b1;
    logic [2:0] baud_sel = 3'd7;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perror;
    logic       rx_ferror;
    logic       rx_busy;

    uart_rx_core #(.CLK_HZ(CLK_HZ)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_en     (rx_en),
        .baud_sel  (baud_sel),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_perror (rx_perror),
        .rx_ferror (rx_ferror),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cmp_e;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         n_perr = 0;
    int         n_ferr = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         t_pulse = 0;
    int         last_busy = 0;
    logic       saw_busy = 1'b0;
    logic [7:0] model_data = 8'h00;

    function automatic int div_of(input logic [2:0] c);
        int b;
        case (c)
            3'd0:    b = 300;
            3'd1:    b = 1200;
            3'd2:    b = 4800;
            3'd3:    b = 9600;
            3'd4:    b = 19200;
            3'd5:    b = 38400;
            3'd6:    b = 57600;
            default: b = 115200;
        endcase
        return (CLK_HZ + 8 * b) / (16 * b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives nbits of {stop, parity, data, start} LSB first; a full frame queues its outcome.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int nbits, input bit mess);
        logic [10:0] fr;
        logic [2:0]  keep;
        int          bc;
        exp_t        e;
        fr   = {stp, par, d, 1'b0};
        keep = baud_sel;
        bc   = 16 * div_of(baud_sel);
        for (int i = 0; i < nbits; i++) begin
            if (i == 10) begin
                e.d  = d;
                e.pe = (par != ^d);
                e.fe = !stp;
                e.v  = stp && (par == ^d);
                exp_q.push_back(e);
            end
            if (i == 0) t_start = cyc;
            if (mess && i == 3) baud_sel = 3'd0;
            rxd = fr[i];
            repeat (bc) @(posedge clk);
            #1;
        end
        baud_sel = keep;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: every pulse must match the next queued frame outcome; rx_data tracks the model.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            model_data = 8'h00;
            chk("reset_outputs", {20'h0, rx_busy, rx_valid, rx_perror, rx_ferror, rx_data}, 32'h0);
        end else begin
            if (rx_valid || rx_perror || rx_ferror) begin
                t_pulse = cyc;
                if (rx_valid)  n_valid++;
                if (rx_perror) n_perr++;
                if (rx_ferror) n_ferr++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got v/pe/fe=%b%b%b expected no pulse",
                             rx_valid, rx_perror, rx_ferror);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("pulse_flags", {29'h0, rx_valid, rx_perror, rx_ferror},
                        {29'h0, cmp_e.v, cmp_e.pe, cmp_e.fe});
                    model_data = cmp_e.d;
                end
            end
            chk("rx_data_model", {24'h0, rx_data}, {24'h0, model_data});
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, rx_busy}, 32'h0);
        chk("reset_data", {24'h0, rx_data}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(10);

        // 0xA5 good frame at 115200, baud_sel disturbed mid-frame
        send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b1);
        chk("a5_data", {24'h0, rx_data}, 32'hA5);
        chk("a5_valid_count", n_valid, 1);
        chk("a5_err_count", n_perr + n_ferr, 0);
        chk_range("a5_latency", t_pulse - t_start, 1178, 1180);
        idle(20);

        // 0x01 with wrong parity
        send_frame(8'h01, 1'b0, 1'b1, 11, 1'b0);
        chk("p01_data", {24'h0, rx_data}, 32'h01);
        chk("p01_perr_count", n_perr, 1);
        chk("p01_valid_count", n_valid, 1);
        idle(20);

        // 9600: framing error, line held low, then a good 0x55
        baud_sel = 3'd3;
        idle(20);
        send_frame(8'h3C, 1'b0, 1'b0, 11, 1'b0);
        chk("f3c_data", {24'h0, rx_data}, 32'h3C);
        chk("f3c_ferr_count", n_ferr, 1);
        chk("f3c_valid_count", n_valid, 1);
        saw_busy = 1'b0;
        for (int i = 0; i < 2 * 16 * div_of(3'd3); i++) begin
            @(negedge clk);
            if (rx_busy) saw_busy = 1'b1;
        end
        chk("low_line_no_restart", {31'h0, saw_busy}, 32'h0);
        @(posedge clk);
        #1 rxd = 1'b1;
        idle(16 * div_of(3'd3));
        send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0);
        chk("g55_data", {24'h0, rx_data}, 32'h55);
        chk("g55_valid_count", n_valid, 2);

        // both errors in one frame
        baud_sel = 3'd7;
        idle(20);
        send_frame(8'h01, 1'b0, 1'b0, 11, 1'b0);
        chk("both_perr_count", n_perr, 2);
        chk("both_ferr_count", n_ferr, 2);
        chk("both_valid_count", n_valid, 2);
        rxd = 1'b1;
        idle(200);

        // 25-clock low glitch (quarter of a 50 MHz 100-clock glitch)
        saw_busy  = 1'b0;
        last_busy = 0;
        rxd = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            if (i == 25) rxd = 1'b1;
            if (rx_busy) begin
                saw_busy  = 1'b1;
                last_busy = i;
            end
        end
        chk("glitch_seen_busy", {31'h0, saw_busy}, 32'h1);
        chk_range("glitch_busy_release", last_busy, 50, 62);
        idle(100);

        // back-to-back 0x12, 0x34
        send_frame(8'h12, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1, 11, 1'b0);
        chk("b2b_data", {24'h0, rx_data}, 32'h34);
        chk("b2b_valid_count", n_valid, 4);
        idle(50);

        // rx_en dropped during DATA of 0xFF
        send_frame(8'hFF, 1'b0, 1'b1, 5, 1'b0);
        @(negedge clk);
        chk("en_abort_busy_before", {31'h0, rx_busy}, 32'h1);
        @(posedge clk);
        #1;
        rx_en = 1'b0;
        rxd   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("en_abort_busy_after", {31'h0, rx_busy}, 32'h0);
        @(posedge clk);
        #1 rx_en = 1'b1;
        idle(1300);
        chk("en_abort_data", {24'h0, rx_data}, 32'h34);
        chk("en_abort_valid_count", n_valid, 4);

        // reset asserted during DATA of 0xFF
        send_frame(8'hFF, 1'b0, 1'b1, 5, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_abort_busy", {31'h0, rx_busy}, 32'h0);
        chk("rst_abort_data", {24'h0, rx_data}, 32'h0);
        rxd = 1'b1;
        idle(5);
        reset = 1'b1;
        idle(1300);
        chk("rst_after_data", {24'h0, rx_data}, 32'h0);
        chk("rst_after_valid_count", n_valid, 4);

        // fresh frame after reset
        send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b0);
        chk("post_rst_data", {24'h0, rx_data}, 32'hA5);
        chk("post_rst_valid_count", n_valid, 5);
        idle(100);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
